// File: rtl/pc_fetch_controller_if.sv
// pc_fetch_controller_if: instruction-memory port (req/ack) and
// execute-stage port (valid/ready) used by the fetch controller.
//
// Parameters:
//   ADDR_W   - fetch address width
//   INSTR_W  - instruction / operand byte width
// Signals:
//   mem_req    controller -> memory   fetch request
//   mem_addr   controller -> memory   fetch address
//   mem_ack    memory -> controller   mem_rdata valid this cycle
//   mem_rdata  memory -> controller   fetched byte
//   exec_valid controller -> execute  instruction offered
//   exec_instr controller -> execute  instruction register
//   exec_ready execute -> controller  instruction accepted
// Modports:
//   master - the fetch controller side
//   slave  - the memory / execute side
interface pc_fetch_controller_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    logic               exec_valid;
    logic [INSTR_W-1:0] exec_instr;
    logic               exec_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output exec_valid,
        output exec_instr,
        input  exec_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  exec_valid,
        input  exec_instr,
        output exec_ready
    );

endinterface

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: owns the program counter, fetches instruction
// bytes, resolves JMP/BRZ and hands ALU instructions to execute.
//
// Parameters:
//   ADDR_W   - PC / fetch address width (must not exceed INSTR_W,
//              since jump targets are taken from one operand byte)
//   INSTR_W  - instruction byte width, opcode in the top two bits
// Ports:
//   input_clk    clock, all state changes on the rising edge
//   input_reset  synchronous active-low reset
//   input_run    start / resume from IDLE or HALT
//   input_zero   datapath zero flag, sampled on the BRZ operand ack
//   input_step   (PC_SINGLE_STEP_EN only) release from PAUSE
//   bus          master side of pc_fetch_controller_if
//   output_Q     current PC
//   halted       high while stopped on a HALT instruction
// Configuration:
//   PC_SINGLE_STEP_EN - when defined, every retired instruction
//   parks in PAUSE until input_step is seen.
//
// Opcodes: 00 ALU, 01 JMP <target>, 10 BRZ <target>, 11 HALT.
// All outputs decode from registered state so no input reaches an
// output combinationally.
module pc_fetch_controller #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic                 input_clk,
    input  logic                 input_reset,
    input  logic                 input_run,
    input  logic                 input_zero,
`ifdef PC_SINGLE_STEP_EN
    input  logic                 input_step,
`endif
    pc_fetch_controller_if.master bus,
    output logic [ADDR_W-1:0]    output_Q,
    output logic                 halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPERAND,
        S_EXEC,
        S_HALT,
        S_PAUSE
    } state_t;

    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_BRZ  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    // Where an instruction goes once it has fully retired.
`ifdef PC_SINGLE_STEP_EN
    localparam state_t S_RETIRE = S_PAUSE;
`else
    localparam state_t S_RETIRE = S_FETCH;
`endif

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_n;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_n;

    logic [1:0]         fetch_op;
    logic [1:0]         ir_op;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    assign fetch_op = bus.mem_rdata[INSTR_W-1 -: 2];
    assign ir_op    = ir[INSTR_W-1 -: 2];
    assign target   = bus.mem_rdata[ADDR_W-1:0];
    // Natural wrap at the top of the address space.
    assign pc_inc   = pc + PC_ONE;

    // ------------------------------------------------------------
    // State register
    // ------------------------------------------------------------
    always_ff @(posedge input_clk) begin
        if (!input_reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
        end
    end

    // ------------------------------------------------------------
    // Next-state, PC and IR update
    // ------------------------------------------------------------
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;

        unique case (state)
            S_IDLE: begin
                if (input_run) begin
                    state_n = S_FETCH;
                end
            end

            S_FETCH: begin
                if (bus.mem_ack) begin
                    ir_n = bus.mem_rdata;
                    pc_n = pc_inc;
                    unique case (fetch_op)
                        OP_ALU:         state_n = S_EXEC;
                        OP_JMP, OP_BRZ: state_n = S_OPERAND;
                        OP_HALT:        state_n = S_HALT;
                        default:        state_n = S_HALT;
                    endcase
                end
            end

            S_OPERAND: begin
                if (bus.mem_ack) begin
                    // An untaken branch just steps over its operand.
                    if (ir_op == OP_BRZ && !input_zero) begin
                        pc_n = pc_inc;
                    end else begin
                        pc_n = target;
                    end
                    state_n = S_RETIRE;
                end
            end

            S_EXEC: begin
                if (bus.exec_ready) begin
                    state_n = S_RETIRE;
                end
            end

            S_HALT: begin
                if (input_run) begin
                    state_n = S_FETCH;
                end
            end

`ifdef PC_SINGLE_STEP_EN
            S_PAUSE: begin
                if (input_step) begin
                    state_n = S_FETCH;
                end
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------
    assign bus.mem_req    = (state == S_FETCH) || (state == S_OPERAND);
    assign bus.mem_addr   = pc;
    assign bus.exec_valid = (state == S_EXEC);
    assign bus.exec_instr = ir;
    assign output_Q       = pc;
    assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller: directed program checks plus randomized
// run with an instruction-level reference model compared every cycle.
module tb_pc_fetch_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic zero;
    logic step;

    always #5 clk = ~clk;

    pc_fetch_controller_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

    logic [7:0] q;
    logic       halted;
    logic [7:0] mem [0:255];

    assign bus.mem_rdata = mem[bus.mem_addr];

    pc_fetch_controller #(.ADDR_W(8), .INSTR_W(8)) dut (
        .input_clk   (clk),
        .input_reset (rst_n),
        .input_run   (run),
        .input_zero  (zero),
`ifdef PC_SINGLE_STEP_EN
        .input_step  (step),
`endif
        .bus         (bus.master),
        .output_Q    (q),
        .halted      (halted)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: what the sequencer is doing, at instruction level.
    localparam int M_IDLE    = 0;
    localparam int M_FETCH   = 1;
    localparam int M_OPERAND = 2;
    localparam int M_OFFER   = 3;
    localparam int M_STOPPED = 4;
    localparam int M_PAUSED  = 5;

    int         ph  = M_IDLE;
    logic [7:0] mpc = 8'h00;
    logic [7:0] mir = 8'h00;

    function automatic int after_retire();
`ifdef PC_SINGLE_STEP_EN
        return M_PAUSED;
`else
        return M_FETCH;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int op;
        if (!rst_n) begin
            ph  = M_IDLE;
            mpc = 8'h00;
            mir = 8'h00;
            return;
        end
        case (ph)
            M_IDLE, M_STOPPED: if (run) ph = M_FETCH;
            M_FETCH: if (bus.mem_ack) begin
                mir = mem[mpc];
                mpc = 8'((int'(mpc) + 1) % 256);
                op  = int'(mir) / 64;
                if (op == 0)      ph = M_OFFER;
                else if (op == 3) ph = M_STOPPED;
                else              ph = M_OPERAND;
            end
            M_OPERAND: if (bus.mem_ack) begin
                op = int'(mir) / 64;
                if (op == 1 || zero) mpc = mem[mpc];
                else mpc = 8'((int'(mpc) + 1) % 256);
                ph = after_retire();
            end
            M_OFFER: if (bus.exec_ready) ph = after_retire();
            M_PAUSED: if (step) ph = M_FETCH;
            default: ph = M_IDLE;
        endcase
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("mem_req", bus.mem_req,
                (ph == M_FETCH || ph == M_OPERAND) ? 1 : 0);
            chk("mem_addr", bus.mem_addr, mpc);
            chk("exec_valid", bus.exec_valid, (ph == M_OFFER) ? 1 : 0);
            chk("exec_instr", bus.exec_instr, mir);
            chk("output_Q", q, mpc);
            chk("halted", halted, (ph == M_STOPPED) ? 1 : 0);
        end
    end

    task automatic tick(input logic r, input logic rn, input logic z,
                        input logic a, input logic rd, input logic st);
        @(negedge clk);
        rst_n          = r;
        run            = rn;
        zero           = z;
        bus.mem_ack    = a;
        bus.exec_ready = rd;
        step           = st;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        zero           = 1'b0;
        step           = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.exec_ready = 1'b0;
        clear_mem();

        // Reset with ack/ready high and run low: stays quiet.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("idle_req", bus.mem_req, 0);
            chk("idle_valid", bus.exec_valid, 0);
            chk("idle_q", q, 8'h00);
            chk("idle_halted", halted, 0);
        end

        // ALU 0x05 then HALT.
        clear_mem();
        mem[8'h00] = 8'h05;
        mem[8'h01] = 8'hC0;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("p1_req", bus.mem_req, 1);
        chk("p1_addr0", bus.mem_addr, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("p1_valid", bus.exec_valid, 1);
        chk("p1_instr", bus.exec_instr, 8'h05);
        chk("p1_model_ir", mir, 8'h05);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PC_SINGLE_STEP_EN
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        chk("p1_addr1", bus.mem_addr, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("p1_halted", halted, 1);
        chk("p1_q", q, 8'h02);
        chk("p1_model_pc", mpc, 8'h02);

        // JMP 0x10 then HALT at 0x10.
        clear_mem();
        mem[8'h00] = 8'h40;
        mem[8'h01] = 8'h10;
        mem[8'h10] = 8'hC0;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("p2_f0", bus.mem_addr, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("p2_f1_req", bus.mem_req, 1);
        chk("p2_f1", bus.mem_addr, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PC_SINGLE_STEP_EN
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        chk("p2_f2_req", bus.mem_req, 1);
        chk("p2_f2", bus.mem_addr, 8'h10);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("p2_halted", halted, 1);
        chk("p2_q", q, 8'h11);
        chk("p2_model_pc", mpc, 8'h11);

        // BRZ taken and not taken.
        for (int z = 1; z >= 0; z--) begin
            clear_mem();
            mem[8'h00] = 8'h80;
            mem[8'h01] = 8'h20;
            do_reset();
            tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, z[0], 1'b1, 1'b0, 1'b0);
`ifdef PC_SINGLE_STEP_EN
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
            chk("brz_req", bus.mem_req, 1);
            chk("brz_addr", bus.mem_addr, z ? 8'h20 : 8'h02);
        end

        // ALU at 0xFF with a stalled execute stage, then reset in a stall.
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem[8'h00] = 8'h40;
            mem[8'h01] = 8'hFF;
            mem[8'hFF] = 8'h07;
            do_reset();
            tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PC_SINGLE_STEP_EN
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
            chk("wrap_fetch", bus.mem_addr, 8'hFF);
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("wrap_q", q, 8'h00);
            chk("wrap_model_pc", mpc, 8'h00);
            for (int i = 0; i < 4; i++) begin
                chk("stall_valid", bus.exec_valid, 1);
                chk("stall_instr", bus.exec_instr, 8'h07);
                tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            chk("stall_valid5", bus.exec_valid, 1);
            chk("stall_instr5", bus.exec_instr, 8'h07);
            if (pass == 0) begin
                tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PC_SINGLE_STEP_EN
                tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
                chk("wrap_next_req", bus.mem_req, 1);
                chk("wrap_next_addr", bus.mem_addr, 8'h00);
            end else begin
                tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                chk("rst_stall_valid", bus.exec_valid, 0);
                chk("rst_stall_q", q, 8'h00);
                tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                chk("rst_stall_req", bus.mem_req, 0);
            end
        end

`ifdef PC_SINGLE_STEP_EN
        // Two ALU instructions: second fetch only after a step pulse.
        clear_mem();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("pause_req", bus.mem_req, 0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("step_req", bus.mem_req, 1);
        chk("step_addr", bus.mem_addr, 8'h01);
`endif

        // Randomized program and handshakes.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0));
            if (c % 500 == 499) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
